oflow_conflict_resolve_fsm: RTL and testbench
=============================================

Name: oflow_conflict_resolve_fsm

Overview:
- Sequences conflict resolution after registration has finished for all sets of a frame.
- Each bbox carries up to two candidate previous-frame IDs (rank 0 = best, rank 1 = second) with similarity scores; candidates are fetched from the score board one at a time.
- Arbitrates between bboxes claiming the same ID: the highest score wins, and the loser falls back to its next candidate or to a fresh ID.
- Streams the final IDs out and drives done_cr / conflict_counter_th toward oflow_core_fsm_top.

Parameters:
- MAX_BBOX, 256, max bboxes per frame.
- BBOX_IDX_LEN, 8, bbox index width.
- ID_LEN, 8, ID width; ID 0 reserved as "no candidate".
- SCORE_LEN, 16, unsigned score width; larger is a better match.
- CONFLICT_TH, 8, max conflict passes before fallback.

Ports:
- clk  in  1  clock
- reset_N  in  1  async active-low reset
- start_cr  in  1  one-cycle start pulse
- num_of_bbox_in_frame  in  9  bboxes in frame, 1..256; sampled at start_cr
- new_id_base  in  ID_LEN  first fresh ID to allocate; sampled at start_cr
- cand_req  out  1  candidate read request
- cand_idx  out  BBOX_IDX_LEN  bbox index requested
- cand_rank  out  1  candidate rank requested
- cand_ack  in  1  candidate data valid
- cand_id  in  ID_LEN  candidate ID; 0 = none
- cand_score  in  SCORE_LEN  candidate score
- id_wr_en  out  1  final ID write strobe
- id_wr_idx  out  BBOX_IDX_LEN  bbox index of the write
- id_wr_data  out  ID_LEN  final ID
- busy  out  1  high from start_cr accepted until done_cr
- done_cr  out  1  one-cycle done pulse
- conflict_counter_th  out  1  fallback taken; held until next start_cr

Behaviour:
- Reset values: all outputs 0, state IDLE.
- Internal state:
  - owner table of 2^ID_LEN entries: valid bit, owner index, score.
  - per bbox: rank bit, resolved bit, final ID.
  - pass counter (ceil(log2(CONFLICT_TH+1)) bits) and new_id counter.
- IDLE:
  - start_cr samples the inputs and clears all table valid bits, resolved bits and rank bits in one cycle, then goes to SCAN.
  - start_cr while busy is ignored.
- SCAN:
  - Walks idx 0..N-1 (N = num_of_bbox_in_frame), skipping resolved bboxes.
  - For each unresolved bbox it asserts cand_req with cand_idx and cand_rank = rank[idx], then goes to WAIT.
- WAIT:
  - cand_req is held until cand_ack, then deasserted the same cycle cand_ack is seen.
  - Latency is arbitrary, at least 1 cycle after req.
  - The ack data is registered, then the block goes to RESOLVE.
- RESOLVE (1 cycle), with id = cand_id and s = cand_score:
  - If id == 0: the bbox is marked for a fresh ID (see FALLBACK).
  - If table[id] is free: claim it; bbox resolved.
  - If the owner's score >= s (ties keep the incumbent): loser; if rank == 0, set rank = 1, else mark for fresh ID; set pass_conflict.
  - If the owner's score < s: evict the owner (owner unresolved; owner rank 0 → 1, rank 1 → marked for fresh ID), claim id; set pass_conflict.
  - Then return to SCAN.
- PASS_END (entered when SCAN reaches N):
  - If no unresolved bbox remains (marked-for-fresh counts as resolved-pending): go to FALLBACK.
  - Otherwise, if pass_conflict: pass++, clear pass_conflict, rescan.
  - If pass reaches CONFLICT_TH: set conflict_counter_th and mark all unresolved bboxes for fresh IDs.
- FALLBACK:
  - In increasing idx order, each fresh-marked bbox gets new_id and new_id increments by 1 per cycle.
  - new_id wraps 2^ID_LEN-1 → 1, skipping 0.
  - Fresh IDs are not checked against claimed IDs; new_id_base is the caller's responsibility.
- WRITE_OUT:
  - N consecutive cycles with id_wr_en = 1, id_wr_idx = 0..N-1 and id_wr_data = final ID.
  - No backpressure.
- DONE: done_cr = 1 for one cycle, busy = 0, return to IDLE.
- Async reset mid-operation: returns to IDLE immediately, clears all outputs and aborts any pending cand_req. No output pulse is generated.
- N == 1: a single RESOLVE, no conflicts possible.

Test Plan:
- N=3, candidates rank0 {5, 7, 9}, scores {100, 100, 100}, ack latency 1 → writes ids {5, 7, 9}, done_cr pulses, conflict_counter_th = 0.
- N=2, both rank0 id 5; bbox0 score 50, bbox1 score 80; bbox0 rank1 = 6 → bbox1 evicts bbox0; second pass gives bbox0 id 6; output {6, 5}.
- Tie: N=2, both rank0 id 4, score 60; bbox1 rank1 = 0; new_id_base = 200 → bbox0 keeps 4, bbox1 gets 200; output {4, 200}.
- CONFLICT_TH=1: bbox0 and bbox1 both rank0 id 3, bbox0 score 10 and bbox1 score 20; bbox0 rank1 id 8; bbox2 rank0 id 8 score 30; new_id_base = 250.
  - Pass 1: bbox1 evicts bbox0 from id 3; bbox2 claims 8; pass_conflict set; pass → 1 = TH.
  - bbox0 is still unresolved → conflict_counter_th = 1; bbox0 gets 250; output {250, 3, 8}.
- Fresh-ID wrap: new_id_base = 255, three bboxes with cand_id 0 → ids {255, 1, 2}.
- Variable ack latency 1..5 cycles, plus start_cr pulsed while busy → results identical to the latency-1 run, second start ignored; reset_N asserted during WAIT → all outputs 0 next edge, no done_cr.

Source files
------------

// File: rtl/oflow_conflict_resolve_fsm.sv
`default_nettype none
// ============================================================================
// Module      : oflow_conflict_resolve_fsm
// Description : Resolves ID conflicts between bboxes of a frame once
//               registration is complete. Candidates are fetched one at a
//               time, the best score keeps an ID, losers fall back to their
//               second candidate or to a freshly allocated ID, and the final
//               IDs are streamed out.
// Revision    : 1.0 - initial release
// ============================================================================
module oflow_conflict_resolve_fsm #(
  parameter int MAX_BBOX     = 256,
  parameter int BBOX_IDX_LEN = 8,
  parameter int ID_LEN       = 8,
  parameter int SCORE_LEN    = 16,
  parameter int CONFLICT_TH  = 8
) (
  input  logic                    clk,
  input  logic                    reset_N,
  input  logic                    start_cr,
  input  logic [BBOX_IDX_LEN:0]   num_of_bbox_in_frame,
  input  logic [ID_LEN-1:0]       new_id_base,
  output logic                    cand_req,
  output logic [BBOX_IDX_LEN-1:0] cand_idx,
  output logic                    cand_rank,
  input  logic                    cand_ack,
  input  logic [ID_LEN-1:0]       cand_id,
  input  logic [SCORE_LEN-1:0]    cand_score,
  output logic                    id_wr_en,
  output logic [BBOX_IDX_LEN-1:0] id_wr_idx,
  output logic [ID_LEN-1:0]       id_wr_data,
  output logic                    busy,
  output logic                    done_cr,
  output logic                    conflict_counter_th
);

  localparam int                  NUM_IDS  = 2 ** ID_LEN;
  localparam int                  PASS_W   = $clog2(CONFLICT_TH + 1);
  localparam logic [PASS_W-1:0]   PASS_MAX = PASS_W'(CONFLICT_TH);
  localparam logic [PASS_W-1:0]   PASS_ONE = PASS_W'(1);
  localparam logic [ID_LEN-1:0]   ID_ONE   = ID_LEN'(1);
  localparam logic [BBOX_IDX_LEN:0] IDX_ONE = (BBOX_IDX_LEN + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SCAN      = 3'd1,
    S_WAIT      = 3'd2,
    S_RESOLVE   = 3'd3,
    S_PASS_END  = 3'd4,
    S_FALLBACK  = 3'd5,
    S_WRITE_OUT = 3'd6,
    S_DONE      = 3'd7
  } state_e;

  state_e                  state_q;
  logic [BBOX_IDX_LEN:0]   n_q;
  logic [BBOX_IDX_LEN:0]   idx_q;
  logic [ID_LEN-1:0]       new_id_q;
  logic [ID_LEN-1:0]       new_id_d;
  logic [PASS_W-1:0]       pass_q;
  logic [PASS_W-1:0]       pass_d;
  logic                    pass_conflict_q;
  logic [ID_LEN-1:0]       cid_q;
  logic [SCORE_LEN-1:0]    cscore_q;

  // Owner table: valid bits live in the reset domain so they can be cleared
  // in a single cycle; owner index and score are plain data storage.
  logic [NUM_IDS-1:0]      tab_valid_q;
  logic [BBOX_IDX_LEN-1:0] tab_owner_q [NUM_IDS];
  logic [SCORE_LEN-1:0]    tab_score_q [NUM_IDS];

  // Per-bbox state. A fresh-marked bbox is also flagged resolved so later
  // passes skip it; it receives its ID during FALLBACK.
  logic [MAX_BBOX-1:0]     rank_q;
  logic [MAX_BBOX-1:0]     resolved_q;
  logic [MAX_BBOX-1:0]     fresh_q;
  logic [ID_LEN-1:0]       final_id_q [MAX_BBOX];

  logic [BBOX_IDX_LEN-1:0] cur;
  logic [MAX_BBOX-1:0]     bbox_mask;
  logic [MAX_BBOX-1:0]     unresolved_vec;
  logic                    any_unresolved;
  logic                    cid_zero;
  logic [BBOX_IDX_LEN-1:0] own_idx;
  logic                    res_claim;
  logic                    res_evict;
  logic                    res_lose;

  // Derived values: active-bbox mask, ID allocator step and arbitration result
  always_comb begin
    cur = idx_q[BBOX_IDX_LEN-1:0];
    for (int i = 0; i < MAX_BBOX; i++) begin
      bbox_mask[i] = (i < int'(n_q));
    end
    unresolved_vec = ~resolved_q & bbox_mask;
    any_unresolved = |unresolved_vec;
    // Fresh IDs wrap from the top value back to 1; 0 means "no candidate"
    new_id_d  = (new_id_q == '1) ? ID_ONE : new_id_q + ID_ONE;
    pass_d    = pass_q + PASS_ONE;
    cid_zero  = (cid_q == '0);
    own_idx   = tab_owner_q[cid_q];
    // Ties keep the incumbent owner
    res_lose  = !cid_zero && tab_valid_q[cid_q] && (tab_score_q[cid_q] >= cscore_q);
    res_evict = !cid_zero && tab_valid_q[cid_q] && (tab_score_q[cid_q] < cscore_q);
    res_claim = !cid_zero && !res_lose;
  end

  // Main sequencer: control state, per-bbox flags and all registered outputs
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q             <= S_IDLE;
      n_q                 <= '0;
      idx_q               <= '0;
      new_id_q            <= '0;
      pass_q              <= '0;
      pass_conflict_q     <= 1'b0;
      cid_q               <= '0;
      cscore_q            <= '0;
      tab_valid_q         <= '0;
      rank_q              <= '0;
      resolved_q          <= '0;
      fresh_q             <= '0;
      cand_req            <= 1'b0;
      cand_idx            <= '0;
      cand_rank           <= 1'b0;
      id_wr_en            <= 1'b0;
      id_wr_idx           <= '0;
      id_wr_data          <= '0;
      busy                <= 1'b0;
      done_cr             <= 1'b0;
      conflict_counter_th <= 1'b0;
    end else begin
      done_cr <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_cr) begin
            n_q                 <= num_of_bbox_in_frame;
            new_id_q            <= new_id_base;
            idx_q               <= '0;
            pass_q              <= '0;
            pass_conflict_q     <= 1'b0;
            tab_valid_q         <= '0;
            rank_q              <= '0;
            resolved_q          <= '0;
            fresh_q             <= '0;
            busy                <= 1'b1;
            conflict_counter_th <= 1'b0;
            state_q             <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (idx_q == n_q) begin
            state_q <= S_PASS_END;
          end else if (resolved_q[cur]) begin
            idx_q <= idx_q + IDX_ONE;
          end else begin
            cand_req  <= 1'b1;
            cand_idx  <= cur;
            cand_rank <= rank_q[cur];
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cand_ack) begin
            cand_req <= 1'b0;
            cid_q    <= cand_id;
            cscore_q <= cand_score;
            state_q  <= S_RESOLVE;
          end
        end
        S_RESOLVE: begin
          if (cid_zero) begin
            resolved_q[cur] <= 1'b1;
            fresh_q[cur]    <= 1'b1;
          end else if (res_lose) begin
            pass_conflict_q <= 1'b1;
            if (!rank_q[cur]) begin
              rank_q[cur] <= 1'b1;
            end else begin
              resolved_q[cur] <= 1'b1;
              fresh_q[cur]    <= 1'b1;
            end
          end else begin
            resolved_q[cur]    <= 1'b1;
            tab_valid_q[cid_q] <= 1'b1;
            if (res_evict) begin
              // Displaced owner retries with its next candidate, or takes a
              // fresh ID if it has already used its second one
              pass_conflict_q <= 1'b1;
              if (!rank_q[own_idx]) begin
                rank_q[own_idx]     <= 1'b1;
                resolved_q[own_idx] <= 1'b0;
              end else begin
                fresh_q[own_idx] <= 1'b1;
              end
            end
          end
          idx_q   <= idx_q + IDX_ONE;
          state_q <= S_SCAN;
        end
        S_PASS_END: begin
          idx_q <= '0;
          if (!any_unresolved) begin
            state_q <= S_FALLBACK;
          end else if (pass_conflict_q && (pass_d < PASS_MAX)) begin
            pass_q          <= pass_d;
            pass_conflict_q <= 1'b0;
            state_q         <= S_SCAN;
          end else begin
            // Pass budget exhausted: everyone still contending gets a fresh
            // ID. An unresolved bbox without a conflict this pass cannot
            // arise, but it is also sent to fallback to rule out looping.
            pass_q              <= pass_d;
            pass_conflict_q     <= 1'b0;
            conflict_counter_th <= pass_conflict_q;
            fresh_q             <= fresh_q | unresolved_vec;
            resolved_q          <= resolved_q | bbox_mask;
            state_q             <= S_FALLBACK;
          end
        end
        S_FALLBACK: begin
          if (idx_q == n_q) begin
            idx_q   <= '0;
            state_q <= S_WRITE_OUT;
          end else begin
            if (fresh_q[cur]) begin
              new_id_q <= new_id_d;
            end
            idx_q <= idx_q + IDX_ONE;
          end
        end
        S_WRITE_OUT: begin
          if (idx_q == n_q) begin
            id_wr_en <= 1'b0;
            done_cr  <= 1'b1;
            busy     <= 1'b0;
            state_q  <= S_DONE;
          end else begin
            id_wr_en   <= 1'b1;
            id_wr_idx  <= cur;
            id_wr_data <= final_id_q[cur];
            idx_q      <= idx_q + IDX_ONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Data storage for table entries and final IDs; validity is held above
  always_ff @(posedge clk) begin
    if ((state_q == S_RESOLVE) && res_claim) begin
      tab_owner_q[cid_q] <= cur;
      tab_score_q[cid_q] <= cscore_q;
      final_id_q[cur]    <= cid_q;
    end
    if ((state_q == S_FALLBACK) && (idx_q != n_q) && fresh_q[cur]) begin
      final_id_q[cur] <= new_id_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_oflow_conflict_resolve_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_oflow_conflict_resolve_fsm
// Description : Directed, table-driven bench for oflow_conflict_resolve_fsm.
//               Two instances: default CONFLICT_TH and CONFLICT_TH = 1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oflow_conflict_resolve_fsm;

  // Candidate/expected fields pack bbox0 in the low byte (or low 16 bits)
  typedef struct packed {
    logic [8:0]  n;
    logic [7:0]  base;
    logic        th1;
    logic        randlat;
    logic [23:0] id0;
    logic [47:0] sc0;
    logic [23:0] id1;
    logic [47:0] sc1;
    logic [23:0] exp_ids;
    logic        exp_cth;
  } vec_t;

  localparam int NV = 7;

  logic        clk = 1'b0;
  logic        reset_N;
  logic        start_cr;
  logic        sel;
  logic [8:0]  num;
  logic [7:0]  base;
  logic        cand_ack;
  logic [7:0]  cand_id;
  logic [15:0] cand_score;

  logic        req0, rank0, wr0, busy0, done0, cth0;
  logic [7:0]  idx0, wridx0, wrdat0;
  logic        req1, rank1, wr1, busy1, done1, cth1;
  logic [7:0]  idx1, wridx1, wrdat1;
  logic        start0, start1;

  logic        m_req, m_rank, m_wr, m_busy, m_done, m_cth;
  logic [7:0]  m_idx, m_wridx, m_wrdat;

  int          chk_cnt = 0;
  int          pass_cnt = 0;
  int          wr_cnt, done_cnt, order_err;
  logic [7:0]  got [256];
  vec_t        vecs [NV];
  vec_t        cur_v;
  logic        hold_ack;
  logic        rand_lat;

  always #5 clk = ~clk;

  assign start0 = start_cr & ~sel;
  assign start1 = start_cr & sel;
  assign m_req   = sel ? req1   : req0;
  assign m_idx   = sel ? idx1   : idx0;
  assign m_rank  = sel ? rank1  : rank0;
  assign m_wr    = sel ? wr1    : wr0;
  assign m_wridx = sel ? wridx1 : wridx0;
  assign m_wrdat = sel ? wrdat1 : wrdat0;
  assign m_busy  = sel ? busy1  : busy0;
  assign m_done  = sel ? done1  : done0;
  assign m_cth   = sel ? cth1   : cth0;

  oflow_conflict_resolve_fsm dut (
    .clk(clk), .reset_N(reset_N), .start_cr(start0),
    .num_of_bbox_in_frame(num), .new_id_base(base),
    .cand_req(req0), .cand_idx(idx0), .cand_rank(rank0),
    .cand_ack(cand_ack & ~sel), .cand_id(cand_id), .cand_score(cand_score),
    .id_wr_en(wr0), .id_wr_idx(wridx0), .id_wr_data(wrdat0),
    .busy(busy0), .done_cr(done0), .conflict_counter_th(cth0)
  );

  oflow_conflict_resolve_fsm #(.CONFLICT_TH(1)) dut_th1 (
    .clk(clk), .reset_N(reset_N), .start_cr(start1),
    .num_of_bbox_in_frame(num), .new_id_base(base),
    .cand_req(req1), .cand_idx(idx1), .cand_rank(rank1),
    .cand_ack(cand_ack & sel), .cand_id(cand_id), .cand_score(cand_score),
    .id_wr_en(wr1), .id_wr_idx(wridx1), .id_wr_data(wrdat1),
    .busy(busy1), .done_cr(done1), .conflict_counter_th(cth1)
  );

  task automatic chk(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic vec_t mk(input int n, input int b, input logic th1, input logic rl,
                              input logic [23:0] id0, input logic [47:0] sc0,
                              input logic [23:0] id1, input logic [47:0] sc1,
                              input logic [23:0] ex, input logic cth);
    vec_t v;
    v.n = 9'(n); v.base = 8'(b); v.th1 = th1; v.randlat = rl;
    v.id0 = id0; v.sc0 = sc0; v.id1 = id1; v.sc1 = sc1;
    v.exp_ids = ex; v.exp_cth = cth;
    return v;
  endfunction

  // Candidate responder: serves the score-board lookups out of cur_v
  initial begin
    int lat;
    int i;
    cand_ack = 1'b0; cand_id = '0; cand_score = '0;
    forever begin
      @(negedge clk);
      if (m_req && !hold_ack) begin
        lat = rand_lat ? int'($urandom_range(1, 5)) : 1;
        for (int k = 1; k < lat; k++) begin
          if (m_req) @(negedge clk);
        end
        if (m_req) begin
          i = int'(m_idx);
          cand_id    = m_rank ? cur_v.id1[8*i +: 8]   : cur_v.id0[8*i +: 8];
          cand_score = m_rank ? cur_v.sc1[16*i +: 16] : cur_v.sc0[16*i +: 16];
          cand_ack   = 1'b1;
          @(negedge clk);
          cand_ack   = 1'b0;
        end
      end
    end
  end

  // Output monitor: captures writes and done pulses
  initial begin
    forever begin
      @(negedge clk);
      if (m_wr) begin
        if (int'(m_wridx) != wr_cnt) order_err++;
        got[m_wridx] = m_wrdat;
        wr_cnt++;
      end
      if (m_done) done_cnt++;
    end
  end

  task automatic clear_obs();
    wr_cnt = 0; done_cnt = 0; order_err = 0;
    for (int i = 0; i < 256; i++) got[i] = 8'd0;
  endtask

  task automatic run_case(input int c, input vec_t v);
    int t;
    sel = v.th1; rand_lat = v.randlat; cur_v = v;
    clear_obs();
    @(negedge clk);
    num = v.n; base = v.base; start_cr = 1'b1;
    @(negedge clk);
    start_cr = 1'b0;
    chk($sformatf("case%0d busy_start", c), int'(m_busy), 1);
    if (v.randlat) begin
      // A second start while busy must be ignored
      repeat (3) @(negedge clk);
      num = 9'd1; base = 8'd77; start_cr = 1'b1;
      @(negedge clk);
      start_cr = 1'b0;
    end
    t = 0;
    while (done_cnt == 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    for (int i = 0; i < int'(v.n); i++)
      chk($sformatf("case%0d id[%0d]", c, i), int'(got[i]), int'(v.exp_ids[8*i +: 8]));
    chk($sformatf("case%0d wr_cnt", c), wr_cnt, int'(v.n));
    chk($sformatf("case%0d wr_order", c), order_err, 0);
    chk($sformatf("case%0d done_cnt", c), done_cnt, 1);
    chk($sformatf("case%0d conflict_th", c), int'(m_cth), int'(v.exp_cth));
    chk($sformatf("case%0d busy_end", c), int'(m_busy), 0);
  endtask

  initial begin
    int t;
    reset_N = 1'b0; start_cr = 1'b0; sel = 1'b0; hold_ack = 1'b0; rand_lat = 1'b0;
    num = '0; base = '0;
    clear_obs();

    //           n  base th1 rl  id0 (b2,b1,b0)          sc0 (b2,b1,b0)                 id1                     sc1                            expected ids            cth
    vecs[0] = mk(3, 1,   0, 0, {8'd9, 8'd7, 8'd5},  {16'd100, 16'd100, 16'd100}, 24'd0,                 48'd0,                         {8'd9, 8'd7, 8'd5},     0);
    vecs[1] = mk(2, 100, 0, 0, {8'd0, 8'd5, 8'd5},  {16'd0, 16'd80, 16'd50},     {8'd0, 8'd0, 8'd6},    {16'd0, 16'd0, 16'd40},        {8'd0, 8'd5, 8'd6},     0);
    vecs[2] = mk(2, 200, 0, 0, {8'd0, 8'd4, 8'd4},  {16'd0, 16'd60, 16'd60},     24'd0,                 48'd0,                         {8'd0, 8'd200, 8'd4},   0);
    vecs[3] = mk(3, 250, 1, 0, {8'd8, 8'd3, 8'd3},  {16'd30, 16'd20, 16'd10},    {8'd0, 8'd0, 8'd8},    {16'd0, 16'd0, 16'd5},         {8'd8, 8'd3, 8'd250},   1);
    vecs[4] = mk(3, 255, 0, 0, 24'd0,               48'd0,                       24'd0,                 48'd0,                         {8'd2, 8'd1, 8'd255},   0);
    vecs[5] = mk(3, 1,   0, 1, {8'd9, 8'd7, 8'd5},  {16'd100, 16'd100, 16'd100}, 24'd0,                 48'd0,                         {8'd9, 8'd7, 8'd5},     0);
    vecs[6] = mk(1, 10,  0, 0, {8'd0, 8'd0, 8'd42}, {16'd0, 16'd0, 16'd7},       24'd0,                 48'd0,                         {8'd0, 8'd0, 8'd42},    0);

    repeat (2) @(negedge clk);
    chk("reset cand_req", int'(req0), 0);
    chk("reset busy", int'(busy0), 0);
    chk("reset done_cr", int'(done0), 0);
    chk("reset id_wr_en", int'(wr0), 0);
    chk("reset conflict_th", int'(cth1), 0);
    reset_N = 1'b1;
    @(negedge clk);

    for (int c = 0; c < NV; c++) run_case(c, vecs[c]);

    // Reset asserted while a candidate request is outstanding
    sel = 1'b0; rand_lat = 1'b0; cur_v = vecs[0]; hold_ack = 1'b1;
    clear_obs();
    @(negedge clk);
    num = 9'd3; base = 8'd1; start_cr = 1'b1;
    @(negedge clk);
    start_cr = 1'b0;
    t = 0;
    while (!req0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("midrst req_seen", int'(req0), 1);
    repeat (2) @(negedge clk);
    reset_N = 1'b0;
    #1;
    chk("midrst cand_req", int'(req0), 0);
    chk("midrst busy", int'(busy0), 0);
    @(negedge clk);
    chk("midrst id_wr_en", int'(wr0), 0);
    reset_N = 1'b1;
    hold_ack = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst done_cnt", done_cnt, 0);
    chk("midrst wr_cnt", wr_cnt, 0);
    chk("midrst busy_after", int'(busy0), 0);

    // Normal operation after the aborted run
    run_case(7, vecs[1]);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
